// File: rtl/fmin2_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fmin2_serial: serial two-minimum / sign finder for a min-sum check-node row |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fmin2_serial #(
  parameter int BITS = 8,
  parameter int DEG  = 8,
  parameter int IDXW = (DEG > 1) ? $clog2(DEG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_llr,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-2:0]   out_min1,
  output logic [BITS-2:0]   out_min2,
  output logic [IDXW-1:0]   out_idx1,
  output logic [DEG-1:0]    out_signs,
  output logic              out_sprod
);

  localparam logic [BITS-2:0] C_MAXMAG  = {(BITS-1){1'b1}};
  localparam logic [IDXW-1:0] C_LASTIDX = IDXW'(DEG - 1);

  logic [BITS-2:0] min1_q, min1_d, min2_q, min2_d;
  logic [IDXW-1:0] idx1_q, idx1_d, cnt_q, cnt_d;
  logic [DEG-1:0]  signs_q, signs_d;
  logic            sprod_q, sprod_d;

  logic [BITS-2:0] omin1_q, omin1_d, omin2_q, omin2_d;
  logic [IDXW-1:0] oidx1_q, oidx1_d;
  logic [DEG-1:0]  osigns_q, osigns_d;
  logic            osprod_q, osprod_d;
  logic            ovalid_q, ovalid_d;

  logic [BITS-1:0] w_neg;
  logic [BITS-2:0] w_mag;
  logic [BITS-2:0] w_min1, w_min2;
  logic [IDXW-1:0] w_idx1;
  logic [DEG-1:0]  w_signs;
  logic            w_sprod;
  logic            w_accept, w_row_end;

  assign in_ready  = !ovalid_q || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_row_end = w_accept && (in_last || (cnt_q == C_LASTIDX));

  always_comb begin
    w_neg = -in_llr;
    // The most negative code has no positive counterpart, so it saturates.
    if (in_llr[BITS-1]) begin
      w_mag = (in_llr[BITS-2:0] == '0) ? C_MAXMAG : w_neg[BITS-2:0];
    end else begin
      w_mag = in_llr[BITS-2:0];
    end

    w_min1 = min1_q;
    w_min2 = min2_q;
    w_idx1 = idx1_q;
    if (w_mag < min1_q) begin
      w_min2 = min1_q;
      w_min1 = w_mag;
      w_idx1 = cnt_q;
    end else if (w_mag < min2_q) begin
      w_min2 = w_mag;
    end
    w_signs        = signs_q;
    w_signs[cnt_q] = in_llr[BITS-1];
    w_sprod        = sprod_q ^ in_llr[BITS-1];
  end

  always_comb begin
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx1_d   = idx1_q;
    signs_d  = signs_q;
    sprod_d  = sprod_q;
    cnt_d    = cnt_q;
    omin1_d  = omin1_q;
    omin2_d  = omin2_q;
    oidx1_d  = oidx1_q;
    osigns_d = osigns_q;
    osprod_d = osprod_q;
    ovalid_d = ovalid_q;

    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end

    if (w_row_end) begin
      omin1_d  = w_min1;
      omin2_d  = w_min2;
      oidx1_d  = w_idx1;
      osigns_d = w_signs;
      osprod_d = w_sprod;
      ovalid_d = 1'b1;
      min1_d   = C_MAXMAG;
      min2_d   = C_MAXMAG;
      idx1_d   = '0;
      signs_d  = '0;
      sprod_d  = 1'b0;
      cnt_d    = '0;
    end else if (w_accept) begin
      min1_d  = w_min1;
      min2_d  = w_min2;
      idx1_d  = w_idx1;
      signs_d = w_signs;
      sprod_d = w_sprod;
      cnt_d   = cnt_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min1_q   <= C_MAXMAG;
      min2_q   <= C_MAXMAG;
      idx1_q   <= '0;
      signs_q  <= '0;
      sprod_q  <= 1'b0;
      cnt_q    <= '0;
      omin1_q  <= '0;
      omin2_q  <= '0;
      oidx1_q  <= '0;
      osigns_q <= '0;
      osprod_q <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      min1_q   <= min1_d;
      min2_q   <= min2_d;
      idx1_q   <= idx1_d;
      signs_q  <= signs_d;
      sprod_q  <= sprod_d;
      cnt_q    <= cnt_d;
      omin1_q  <= omin1_d;
      omin2_q  <= omin2_d;
      oidx1_q  <= oidx1_d;
      osigns_q <= osigns_d;
      osprod_q <= osprod_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out_min1  = omin1_q;
  assign out_min2  = omin2_q;
  assign out_idx1  = oidx1_q;
  assign out_signs = osigns_q;
  assign out_sprod = osprod_q;

endmodule
`default_nettype wire

// File: tb/tb_fmin2_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fmin2_serial: scoreboard bench for fmin2_serial (BITS=8, DEG=4)         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fmin2_serial;

  localparam int BITS = 8;
  localparam int DEG  = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_llr = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [BITS-2:0] out_min1, out_min2;
  logic [IDXW-1:0] out_idx1;
  logic [DEG-1:0]  out_signs;
  logic            out_sprod;

  typedef struct packed {
    logic [6:0] m1;
    logic [1:0] idx;
    logic [6:0] m2;
    logic [3:0] signs;
    logic       sprod;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  fmin2_serial #(.BITS(BITS), .DEG(DEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min1  (out_min1),
    .out_min2  (out_min2),
    .out_idx1  (out_idx1),
    .out_signs (out_signs),
    .out_sprod (out_sprod)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_row(input int m1, input int idx, input int m2,
                            input logic [3:0] signs, input logic sprod);
    exp_t e;
    e.m1 = 7'(m1); e.idx = 2'(idx); e.m2 = 7'(m2); e.signs = signs; e.sprod = sprod;
    q.push_back(e);
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic send(input int v, input logic last);
    logic ok;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    in_llr   = 8'(v);
    in_last  = last;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: actual=stalled required=accepted");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected result per completed output handshake.
  always @(negedge clk) begin
    exp_t e, a;
    if (!rst && out_valid && out_ready) begin
      a = {out_min1, out_idx1, out_min2, out_signs, out_sprod};
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: actual=%0h required=none", a);
      end else begin
        e = q.pop_front();
        chk("row_result", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int          n;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_outputs", {out_min1, out_idx1, out_min2, out_signs, out_sprod}, 0);
    @(posedge clk);
    #1;

    // Full rows, then a back-to-back row with ties
    expect_row(1, 0, 4, 4'b1111, 1'b0);
    send(-1, 0); send(-20, 0); send(-30, 0); send(-4, 0);
    expect_row(5, 0, 40, 4'b0100, 1'b1);
    send(5, 0); send(81, 0); send(-40, 0); send(40, 0);
    expect_row(7, 0, 7, 4'b0100, 1'b1);
    send(7, 0); send(7, 0); send(-7, 0); send(9, 0);

    // Saturation and early row end, single-edge row
    expect_row(3, 1, 127, 4'b0001, 1'b1);
    send(-128, 0); send(3, 1);
    expect_row(10, 0, 127, 4'b0000, 1'b0);
    send(10, 1);
    idle();

    // Back-pressure
    out_ready = 1'b0;
    expect_row(50, 0, 60, 4'b1010, 1'b0);
    send(50, 0); send(-60, 0); send(70, 0); send(-80, 1);
    in_valid = 1'b1; in_llr = 8'd30; in_last = 1'b0;
    @(negedge clk);
    snap = {out_min1, out_idx1, out_min2, out_signs, out_sprod};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_stable", {out_min1, out_idx1, out_min2, out_signs, out_sprod}, snap);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    expect_row(10, 1, 20, 4'b0010, 1'b1);
    send(30, 0); send(-10, 0); send(20, 1);
    idle();

    // Reset mid-row discards the partial row
    send(-1, 0); send(-2, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid_during", 32'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_after", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    expect_row(2, 1, 4, 4'b0000, 1'b0);
    send(6, 0); send(2, 0); send(9, 0); send(4, 0);

    // Gapped input matches the gap-free run of the same data
    expect_row(3, 1, 3, 4'b0101, 1'b0);
    send(-9, 0); idle(); send(3, 0); idle(); send(-3, 0); idle(); send(100, 0);
    expect_row(3, 1, 3, 4'b0101, 1'b0);
    send(-9, 0); send(3, 0); send(-3, 0); send(100, 0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
